// File: rtl/br_pkg.sv
// Shared definitions for the game controller: scene encoding, PS/2 key codes
// and the saturating score adder.
package br_pkg;

    typedef enum logic [1:0] {
        SCENE_TITLE = 2'b00,
        SCENE_PLAY  = 2'b01,
        SCENE_PAUSE = 2'b10,
        SCENE_OVER  = 2'b11
    } scene_e;

    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_ESC   = 8'h76;

    localparam int         SCORE_W   = 14;
    localparam int         SPEED_W   = 3;
    localparam logic [2:0] SPEED_TOP = 3'd7;

    // Points per frame are speed+1; the sum is one bit wider so the cap compare sees overflow.
    function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] score,
                                                    input logic [SPEED_W-1:0] speed,
                                                    input logic [SCORE_W-1:0] cap);
        logic [SCORE_W:0] sum;
        sum = {1'b0, score} + {{(SCORE_W-SPEED_W+1){1'b0}}, speed} + {{SCORE_W{1'b0}}, 1'b1};
        return (sum > {1'b0, cap}) ? cap : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/br_edge_det.sv
// Registered falling-edge detector; history resets high and the pulse output
// resets low, so no pulse can appear in the first cycle after reset.
module br_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic fall_o
);

    logic prev_q;
    logic fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            fall_q <= prev_q & ~sig_i;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/br_game_ctrl.sv
// Game sequencer: scene FSM, per-frame update handshake with the model unit,
// score/speed bookkeeping.
//
//   state | meaning
//   TITLE | waiting for Enter, nothing counted
//   PLAY  | frames ticking, one model update per frame
//   PAUSE | frozen, P resumes, Esc quits to title
//   OVER  | collision seen, score/speed frozen until Enter
module br_game_ctrl
    import br_pkg::*;
#(
    parameter int FRAMES_PER_LEVEL = 512,
    parameter int SCORE_MAX        = 9999
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 vsync,
    input  logic                 key_valid,
    input  logic [7:0]           key_code,
    input  logic                 collision,
    input  logic                 upd_ack,
    output logic                 upd_req,
    output logic [1:0]           scene,
    output logic [SPEED_W-1:0]   speed,
    output logic [SCORE_W-1:0]   score,
    output logic                 missed
);

    localparam int                 FCW       = $clog2(FRAMES_PER_LEVEL);
    localparam logic [FCW-1:0]     FC_LAST   = FCW'(FRAMES_PER_LEVEL - 1);
    localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

    scene_e               state_q, state_d;
    logic                 upd_req_q, upd_req_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 missed_q, missed_d;
    logic [FCW-1:0]       fcnt_q, fcnt_d;
    logic                 pause_pend_q, pause_pend_d;

    logic frame_tick;
    logic key_enter, key_p, key_esc;
    logic ack_ok;

    br_edge_det u_vsync_edge (
        .clk    (clk),
        .rst_n  (clr),
        .sig_i  (vsync),
        .fall_o (frame_tick)
    );

    assign key_enter = key_valid && (key_code == KEY_ENTER);
    assign key_p     = key_valid && (key_code == KEY_P);
    assign key_esc   = key_valid && (key_code == KEY_ESC);
    assign ack_ok    = upd_ack && upd_req_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= SCENE_TITLE;
            upd_req_q    <= 1'b0;
            speed_q      <= '0;
            score_q      <= '0;
            missed_q     <= 1'b0;
            fcnt_q       <= '0;
            pause_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            upd_req_q    <= upd_req_d;
            speed_q      <= speed_d;
            score_q      <= score_d;
            missed_q     <= missed_d;
            fcnt_q       <= fcnt_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        upd_req_d    = upd_req_q;
        speed_d      = speed_q;
        score_d      = score_q;
        missed_d     = missed_q;
        fcnt_d       = fcnt_q;
        pause_pend_d = pause_pend_q;

        case (state_q)
            SCENE_TITLE: begin
                if (key_enter) begin
                    state_d      = SCENE_PLAY;
                    upd_req_d    = 1'b0;
                    speed_d      = '0;
                    score_d      = '0;
                    missed_d     = 1'b0;
                    fcnt_d       = '0;
                    pause_pend_d = 1'b0;
                end
            end

            SCENE_PLAY: begin
                if (collision) begin
                    state_d      = SCENE_OVER;
                    upd_req_d    = 1'b0;
                    pause_pend_d = 1'b0;
                end else begin
                    if (ack_ok) begin
                        upd_req_d = 1'b0;
                        score_d   = score_add(score_q, speed_q, SCORE_CAP);
                        if (fcnt_q == FC_LAST) begin
                            fcnt_d = '0;
                            if (speed_q != SPEED_TOP) speed_d = speed_q + 3'd1;
                        end else begin
                            fcnt_d = fcnt_q + FCW'(1);
                        end
                    end

                    if (frame_tick) begin
                        if (upd_req_q) missed_d  = 1'b1;
                        else           upd_req_d = 1'b1;
                    end

                    // Pause waits for an outstanding update so the model never sees a half frame.
                    if (key_p || pause_pend_q) begin
                        if (upd_req_q && !upd_ack) begin
                            pause_pend_d = 1'b1;
                        end else begin
                            state_d      = SCENE_PAUSE;
                            upd_req_d    = 1'b0;
                            pause_pend_d = 1'b0;
                        end
                    end
                end
            end

            SCENE_PAUSE: begin
                if (key_p)        state_d = SCENE_PLAY;
                else if (key_esc) state_d = SCENE_TITLE;
            end

            SCENE_OVER: begin
                if (key_enter) state_d = SCENE_TITLE;
            end

            default: state_d = SCENE_TITLE;
        endcase
    end

    assign upd_req = upd_req_q;
    assign scene   = state_q;
    assign speed   = speed_q;
    assign score   = score_q;
    assign missed  = missed_q;

endmodule

// File: tb/tb_br_game_ctrl.sv
// Self-checking bench for br_game_ctrl with FRAMES_PER_LEVEL=4; a score/speed
// model pushes expectations to a queue on every ack, popped after the DUT updates.
module tb_br_game_ctrl;

    localparam int FPL  = 4;
    localparam int SMAX = 9999;

    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_P     = 8'h4D;
    localparam logic [7:0] K_ESC   = 8'h76;
    localparam logic [7:0] K_OTHER = 8'h1C;

    logic        clk;
    logic        clr;
    logic        vsync;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        collision;
    logic        upd_ack;
    logic        upd_req;
    logic [1:0]  scene;
    logic [2:0]  speed;
    logic [13:0] score;
    logic        missed;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int score;
        int speed;
    } exp_t;
    exp_t sb_q[$];

    int m_score, m_speed, m_fcnt;

    br_game_ctrl #(
        .FRAMES_PER_LEVEL (FPL),
        .SCORE_MAX        (SMAX)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .vsync     (vsync),
        .key_valid (key_valid),
        .key_code  (key_code),
        .collision (collision),
        .upd_ack   (upd_ack),
        .upd_req   (upd_req),
        .scene     (scene),
        .speed     (speed),
        .score     (score),
        .missed    (missed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        m_score = 0;
        m_speed = 0;
        m_fcnt  = 0;
        sb_q.delete();
    endtask

    task automatic model_step();
        exp_t e;
        m_score = (m_score + m_speed + 1 > SMAX) ? SMAX : m_score + m_speed + 1;
        if (m_fcnt == FPL - 1) begin
            m_fcnt = 0;
            if (m_speed < 7) m_speed++;
        end else begin
            m_fcnt++;
        end
        e.score = m_score;
        e.speed = m_speed;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        clr       = 1'b0;
        vsync     = 1'b1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        collision = 1'b0;
        upd_ack   = 1'b0;
        tick_n(3);
        clr = 1'b1;
        tick_n(1);
        model_clear();
    endtask

    task automatic press(input logic [7:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic vsync_fall();
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (upd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s wait_req: upd_req=%b after 10 cycles, required 1", name, upd_req);
        end
    endtask

    task automatic do_ack(input int delay, input string name);
        exp_t e;
        tick_n(delay);
        upd_ack = 1'b1;
        model_step();
        @(negedge clk);
        upd_ack = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (score !== 14'(e.score)) begin
            errors++;
            $display("FAIL %s score: got %0d required %0d", name, score, e.score);
        end
        checks++;
        if (speed !== 3'(e.speed)) begin
            errors++;
            $display("FAIL %s speed: got %0d required %0d", name, speed, e.speed);
        end
        checks++;
        if (upd_req !== 1'b0) begin
            errors++;
            $display("FAIL %s upd_req_drop: got %b required 0", name, upd_req);
        end
    endtask

    task automatic do_frame(input int delay, input string name);
        bit ok;
        vsync_fall();
        wait_req(name, ok);
        if (ok) do_ack(delay, name);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (scene !== 2'b00) begin errors++; $display("FAIL reset scene: got %b required 00", scene); end
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL reset upd_req: got %b required 0", upd_req); end
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL reset speed: got %0d required 0", speed); end
        checks++; if (score !== 14'd0) begin errors++; $display("FAIL reset score: got %0d required 0", score); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL reset missed: got %b required 0", missed); end
        vsync_fall();
        tick_n(3);
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL title_no_req upd_req: got %b required 0", upd_req); end
        press(K_OTHER);
        checks++; if (scene !== 2'b00) begin errors++; $display("FAIL title_other_key scene: got %b required 00", scene); end
        press(K_P);
        checks++; if (scene !== 2'b00) begin errors++; $display("FAIL title_p_key scene: got %b required 00", scene); end
    endtask

    task automatic test_basic();
        do_reset();
        press(K_ENTER);
        model_clear();
        checks++; if (scene !== 2'b01) begin errors++; $display("FAIL basic_enter scene: got %b required 01", scene); end
        repeat (3) do_frame(2, "basic");
        checks++; if (score !== 14'd3) begin errors++; $display("FAIL basic score: got %0d required 3", score); end
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL basic speed: got %0d required 0", speed); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL basic missed: got %b required 0", missed); end
        checks++; if (scene !== 2'b01) begin errors++; $display("FAIL basic scene: got %b required 01", scene); end
    endtask

    task automatic test_levels();
        do_reset();
        press(K_ENTER);
        model_clear();
        for (int f = 1; f <= 40; f++) do_frame(1, "levels");
        checks++; if (speed !== 3'd7) begin errors++; $display("FAIL levels_final speed: got %0d required 7", speed); end
        checks++; if (score !== 14'd208) begin errors++; $display("FAIL levels_final score: got %0d required 208", score); end
    endtask

    task automatic test_missed();
        bit ok;
        do_reset();
        press(K_ENTER);
        model_clear();
        vsync_fall();
        wait_req("missed", ok);
        vsync_fall();
        tick_n(3);
        checks++; if (upd_req !== 1'b1) begin errors++; $display("FAIL missed_hold upd_req: got %b required 1", upd_req); end
        checks++; if (missed !== 1'b1) begin errors++; $display("FAIL missed_flag missed: got %b required 1", missed); end
        checks++; if (score !== 14'd0) begin errors++; $display("FAIL missed_noscore score: got %0d required 0", score); end
        do_ack(0, "missed_ack");
        tick_n(4);
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL missed_no_second upd_req: got %b required 0", upd_req); end
        checks++; if (score !== 14'd1) begin errors++; $display("FAIL missed_once score: got %0d required 1", score); end
        checks++; if (missed !== 1'b1) begin errors++; $display("FAIL missed_sticky missed: got %b required 1", missed); end
    endtask

    task automatic test_pause();
        bit ok;
        do_reset();
        press(K_ENTER);
        model_clear();
        vsync_fall();
        wait_req("pause", ok);
        press(K_P);
        checks++; if (scene !== 2'b01) begin errors++; $display("FAIL pause_deferred scene: got %b required 01", scene); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (scene !== 2'b01) begin errors++; $display("FAIL pause_wait%0d scene: got %b required 01", i, scene); end
        end
        do_ack(0, "pause_ack");
        checks++; if (scene !== 2'b10) begin errors++; $display("FAIL pause_enter scene: got %b required 10", scene); end
        vsync_fall();
        tick_n(3);
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL pause_no_req upd_req: got %b required 0", upd_req); end
        press(K_P);
        checks++; if (scene !== 2'b01) begin errors++; $display("FAIL pause_resume scene: got %b required 01", scene); end
        press(K_P);
        checks++; if (scene !== 2'b10) begin errors++; $display("FAIL pause_immediate scene: got %b required 10", scene); end
        press(K_ESC);
        checks++; if (scene !== 2'b00) begin errors++; $display("FAIL pause_esc scene: got %b required 00", scene); end
    endtask

    task automatic test_collision();
        bit ok;
        do_reset();
        press(K_ENTER);
        model_clear();
        do_frame(1, "coll_frame");
        vsync_fall();
        wait_req("coll", ok);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        checks++; if (scene !== 2'b11) begin errors++; $display("FAIL coll_over scene: got %b required 11", scene); end
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL coll_drop upd_req: got %b required 0", upd_req); end
        upd_ack = 1'b1;
        @(negedge clk);
        upd_ack = 1'b0;
        checks++; if (score !== 14'd1) begin errors++; $display("FAIL coll_late_ack score: got %0d required 1", score); end
        press(K_P);
        checks++; if (scene !== 2'b11) begin errors++; $display("FAIL coll_p_ignored scene: got %b required 11", scene); end
        press(K_ENTER);
        checks++; if (scene !== 2'b00) begin errors++; $display("FAIL coll_enter scene: got %b required 00", scene); end
        press(K_ENTER);
        key_valid = 1'b1;
        key_code  = K_P;
        collision = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
        collision = 1'b0;
        checks++; if (scene !== 2'b11) begin errors++; $display("FAIL coll_wins scene: got %b required 11", scene); end
    endtask

    task automatic test_sat_reset();
        bit ok;
        int guard;
        do_reset();
        press(K_ENTER);
        model_clear();
        guard = 0;
        while (m_score < SMAX && guard < 2000) begin
            do_frame(0, "sat");
            guard++;
        end
        do_frame(0, "sat_extra");
        checks++; if (score !== 14'd9999) begin errors++; $display("FAIL sat score: got %0d required 9999", score); end
        checks++; if (speed !== 3'd7) begin errors++; $display("FAIL sat speed: got %0d required 7", speed); end
        vsync_fall();
        wait_req("sat_midreq", ok);
        clr = 1'b0;
        #1;
        checks++; if (scene !== 2'b00) begin errors++; $display("FAIL clr_async scene: got %b required 00", scene); end
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL clr_async upd_req: got %b required 0", upd_req); end
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL clr_async speed: got %0d required 0", speed); end
        checks++; if (score !== 14'd0) begin errors++; $display("FAIL clr_async score: got %0d required 0", score); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL clr_async missed: got %b required 0", missed); end
        @(negedge clk);
        clr = 1'b1;
        tick_n(3);
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL clr_release upd_req: got %b required 0", upd_req); end
        press(K_ENTER);
        model_clear();
        tick_n(3);
        checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL clr_no_early_req upd_req: got %b required 0", upd_req); end
        do_frame(1, "clr_first_frame");
    endtask

    initial begin
        clr       = 1'b0;
        vsync     = 1'b1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        collision = 1'b0;
        upd_ack   = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_levels();
        test_missed();
        test_pause();
        test_collision();
        test_sat_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/br_game_ctrl.md
BR_GAME_CTRL -- requirements
Module: br_game_ctrl

Interface
REQ-001 Parameter FRAMES_PER_LEVEL, default 512, is the number of PLAY frames per speed increment (range 2..4096).
REQ-002 Parameter SCORE_MAX, default 9999, is the score saturation value (must fit in 14 bits).
REQ-003 clk  in  1  system clock; the only clock in the block.
REQ-004 clr  in  1  reset; asynchronous, active-low.
REQ-005 vsync  in  1  active-low vertical sync from the renderer, synchronous to clk.
REQ-006 key_valid  in  1  one-cycle strobe: key_code holds a completed PS/2 make code.
REQ-007 key_code  in  8  PS/2 set-2 make code.
REQ-008 collision  in  1  level from the model unit: player overlaps an obstacle.
REQ-009 upd_ack  in  1  one-cycle strobe from the model unit: per-frame update finished.
REQ-010 upd_req  out  1  per-frame model update request, held until acknowledged.
REQ-011 scene  out  2  scene select for renderer: 00 TITLE, 01 PLAY, 10 PAUSE, 11 OVER.
REQ-012 speed  out  3  scroll speed level 0..7 for the model.
REQ-013 score  out  14  binary score for the 7-segment path.
REQ-014 missed  out  1  sticky flag: a frame tick arrived while upd_req was still pending.

Function
REQ-015 Frame tick: one-cycle internal pulse on each vsync falling edge (registered previous vsync, 1 -> 0); no tick in the first cycle after reset.
REQ-016 Game FSM states TITLE, PLAY, PAUSE, OVER; scene output is the registered state encoding.
REQ-017 TITLE -> PLAY on key_valid with key_code 0x5A (Enter); score, speed, frame counter, missed all cleared on that transition.
REQ-018 PLAY -> PAUSE on key_valid with key_code 0x4D (P); if upd_req is pending, the transition is deferred until the cycle after upd_ack.
REQ-019 PAUSE -> PLAY on key 0x4D; PAUSE -> TITLE on key 0x76 (Esc).
REQ-020 PLAY -> OVER in the cycle after collision is sampled high; upd_req drops in that same transition (pending request abandoned, later upd_ack ignored).
REQ-021 OVER -> TITLE on key 0x5A; score and speed hold their values in OVER until leaving it.
REQ-022 Key codes other than those listed are ignored in every state; key_valid and collision in the same cycle: collision wins.
REQ-023 Update handshake, PLAY only: on frame tick with upd_req low, upd_req rises next cycle; it stays high until upd_ack is sampled high, then falls next cycle.
REQ-024 Frame tick while upd_req high: no new request, missed set to 1, cleared only by reset or TITLE -> PLAY.
REQ-025 upd_ack while upd_req low: ignored.
REQ-026 On each accepted upd_ack: score += speed + 1, saturating at SCORE_MAX; frame counter increments.
REQ-027 Frame counter wraps from FRAMES_PER_LEVEL-1 to 0; on wrap, speed increments, saturating at 7.
REQ-028 No frame ticks are counted and no requests are issued in TITLE, PAUSE, or OVER.

Reset
REQ-029 While clr is low: state TITLE, upd_req 0, scene 00, speed 0, score 0, missed 0, frame counter 0, vsync history register 1.
REQ-030 Reset assertion mid-handshake abandons the request immediately; after clr releases, no request is issued before the next PLAY frame tick.

Structure
REQ-031 Shared package br_pkg holds the scene encoding (2-bit enum) and the key-code constants KEY_ENTER 0x5A, KEY_P 0x4D, KEY_ESC 0x76.
REQ-032 One sub-module, br_edge_det (registered falling-edge detector, async active-low reset, reset value 1), generates the frame tick.
REQ-033 All outputs are driven directly from registers; no combinational path from inputs to outputs.

Verification
REQ-034 Reset, Enter, 3 vsync falls, each acked 2 cycles after upd_req -> scene 01, score 3, speed 0, missed 0.
REQ-035 FRAMES_PER_LEVEL=4, 40 acked frames -> speed increments at frames 4, 8, ..., 28, then stays at 7; score = 1+1+1+1+2+... (sum per REQ-026), checked per frame.
REQ-036 Hold upd_ack off across 2 vsync falls -> single upd_req held high, missed 1; after ack, score increments once.
REQ-037 P pressed while upd_req high, ack 5 cycles later -> scene stays 01 until the cycle after ack, then 10; P again -> 01.
REQ-038 Collision with upd_req high -> next cycle scene 11, upd_req 0; late upd_ack leaves score unchanged; Enter -> 00.
REQ-039 Preload score near SCORE_MAX via play with speed 7 -> score saturates at 9999; clr pulsed low mid-request -> all outputs at reset values within the same cycle.
